ps2_scan_receiver: RTL and testbench

//   PS/2 keyboard receiver: deserialises device-to-host frames from the ps2clk/ps2data lines.

---
 rtl/ps2_scan_receiver.sv | 149 ++++++++++++++
 tb/tb_ps2_scan_receiver.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_receiver.sv
// PS/2 device-to-host receiver.
// Synchronises and glitch-filters the PS/2 lines, deframes 11-bit frames
// (start, 8 data LSB first, odd parity, stop) and presents each good byte on
// scan with a one-clk scan_received strobe. Bad or stalled frames produce a
// one-clk frame_err pulse instead and leave scan untouched.
//
// Handshake: scan_received is a single-cycle valid with no ready; the consumer
// must take scan on the cycle the strobe is high (scan also holds afterwards).
module ps2_scan_receiver #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 14000,
    parameter int TOUT_W     = 14
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2clk,
    input  logic       ps2data,
    output logic [7:0] scan,
    output logic       scan_received,
    output logic       frame_err,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    logic                  clk_s1_q, clk_s2_q;
    logic                  dat_s1_q, dat_s2_q;
    logic [FILTER_LEN-1:0] filt_sr_q;
    logic                  filt_clk_q, filt_clk_d;
    logic                  fall;

    state_t                state_q;
    logic [2:0]            bit_cnt_q;
    logic [7:0]            shift_q;
    logic                  parity_q;
    logic [TOUT_W-1:0]     tout_q;
    logic [7:0]            scan_q;
    logic                  scan_received_q;
    logic                  frame_err_q;

    // Two-flop synchronisers; both idle high so reset looks like a quiet bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2data;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Filtered level only moves when the whole sample window agrees.
    always_comb begin
        filt_clk_d = filt_clk_q;
        if (&filt_sr_q) begin
            filt_clk_d = 1'b1;
        end else if (~|filt_sr_q) begin
            filt_clk_d = 1'b0;
        end
    end

    // A falling edge of the filtered clock is the cycle it is about to drop.
    assign fall = filt_clk_q & ~filt_clk_d;

    // Glitch filter window and filtered level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_sr_q  <= {FILTER_LEN{1'b1}};
            filt_clk_q <= 1'b1;
        end else begin
            filt_sr_q  <= {filt_sr_q[FILTER_LEN-2:0], clk_s2_q};
            filt_clk_q <= filt_clk_d;
        end
    end

    // Frame state machine, timeout counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            bit_cnt_q       <= 3'd0;
            shift_q         <= 8'h00;
            parity_q        <= 1'b0;
            tout_q          <= '0;
            scan_q          <= 8'h00;
            scan_received_q <= 1'b0;
            frame_err_q     <= 1'b0;
        end else begin
            scan_received_q <= 1'b0;
            frame_err_q     <= 1'b0;

            if (fall || state_q == S_IDLE) begin
                tout_q <= '0;
            end else if (tout_q != {TOUT_W{1'b1}}) begin
                tout_q <= tout_q + 1'b1;
            end

            if (fall) begin
                // A bit arriving on the timeout cycle still counts.
                case (state_q)
                    S_IDLE: begin
                        if (!dat_s2_q) begin
                            state_q   <= S_DATA;
                            bit_cnt_q <= 3'd0;
                        end
                    end
                    S_DATA: begin
                        shift_q   <= {dat_s2_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        parity_q <= dat_s2_q;
                        state_q  <= S_STOP;
                    end
                    S_STOP: begin
                        if (dat_s2_q && (^{shift_q, parity_q})) begin
                            scan_q          <= shift_q;
                            scan_received_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end else if (state_q != S_IDLE && tout_q >= TOUT_W'(TIMEOUT)) begin
                state_q     <= S_IDLE;
                frame_err_q <= 1'b1;
            end
        end
    end

    assign scan          = scan_q;
    assign scan_received = scan_received_q;
    assign frame_err     = frame_err_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Bench for ps2_scan_receiver: drives PS/2 frames bit by bit, queues the
// expected bytes, and a monitor pops and compares them on every strobe.
module tb_ps2_scan_receiver;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 14000;
  localparam int TOUT_W     = 14;
  localparam int HALF       = 24;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2clk = 1'b1;
  logic       ps2data = 1'b1;
  logic [7:0] scan;
  logic       scan_received;
  logic       frame_err;
  logic [1:0] state_dbg;

  int checks   = 0;
  int errors   = 0;
  int err_seen = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;
  logic       prev_sr = 1'b0;

  // clock / reset
  always #5 clk = ~clk;

  ps2_scan_receiver #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT(TIMEOUT),
    .TOUT_W(TOUT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ps2clk(ps2clk),
    .ps2data(ps2data),
    .scan(scan),
    .scan_received(scan_received),
    .frame_err(frame_err),
    .state_dbg(state_dbg)
  );

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (scan_received) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe scan=%02h expected no strobe", scan);
        end else begin
          exp_v = exp_q.pop_front();
          if (scan !== exp_v) begin
            errors++;
            $display("FAIL strobe_byte scan=%02h expected=%02h", scan, exp_v);
          end
        end
        checks++;
        if (prev_sr) begin
          errors++;
          $display("FAIL strobe_width scan_received high 2+ clks, expected 1");
        end
        checks++;
        if (frame_err) begin
          errors++;
          $display("FAIL both_strobes frame_err=1 with scan_received=1, expected 0");
        end
      end
      if (frame_err) err_seen++;
    end
    prev_sr = scan_received;
  end

  function automatic logic odd_par(input logic [7:0] b);
    return ~(^b);
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  // driver: one bit = high phase (data set) then low phase
  task automatic send_bit(input logic b, input bit glitch);
    @(negedge clk);
    ps2data = b;
    if (glitch) begin
      wait_clks(4);
      ps2clk = 1'b0;
      wait_clks(FILTER_LEN - 1);
      ps2clk = 1'b1;
      wait_clks(HALF - 4 - (FILTER_LEN - 1));
    end else begin
      wait_clks(HALF);
    end
    ps2clk = 1'b0;
    if (glitch) begin
      wait_clks(12);
      ps2clk = 1'b1;
      wait_clks(FILTER_LEN - 1);
      ps2clk = 1'b0;
      wait_clks(HALF - 12 - (FILTER_LEN - 1));
    end else begin
      wait_clks(HALF);
    end
    ps2clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                            input bit glitch);
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
    send_bit(par, glitch);
    send_bit(stop, glitch);
    wait_clks(HALF);
  endtask

  task automatic check_drained(input string name, input int err_before, input int err_exp);
    wait_clks(40);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_strobe pending=%0d expected 0", name, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (err_seen - err_before !== err_exp) begin
      errors++;
      $display("FAIL %s_frame_err count=%0d expected=%0d", name, err_seen - err_before, err_exp);
    end
  endtask

  task automatic check_scan(input string name, input logic [7:0] exp);
    @(negedge clk);
    checks++;
    if (scan !== exp) begin
      errors++;
      $display("FAIL %s_scan scan=%02h expected=%02h", name, scan, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clks(5);
    @(negedge clk);
    checks++;
    if ({scan, scan_received, frame_err, state_dbg} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs scan=%02h sr=%b fe=%b st=%0d expected 00 0 0 0",
               scan, scan_received, frame_err, state_dbg);
    end
    rst = 1'b0;
    wait_clks(20);
  endtask

  task automatic test_clean();
    int e0 = err_seen;
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check_drained("clean", e0, 0);
    check_scan("clean", 8'h1C);
  endtask

  task automatic test_sequence();
    logic [7:0] seq [3];
    int e0 = err_seen;
    seq[0] = 8'hE0; seq[1] = 8'hF0; seq[2] = 8'h75;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(seq[i]);
      send_frame(seq[i], odd_par(seq[i]), 1'b1, 1'b0);
    end
    check_drained("sequence", e0, 0);
    check_scan("sequence", 8'h75);
  endtask

  task automatic test_random();
    int e0 = err_seen;
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_frame(b, odd_par(b), 1'b1, 1'b0);
    end
    check_drained("random", e0, 0);
    check_scan("random", b);
    exp_q.push_back(8'h75);
    send_frame(8'h75, odd_par(8'h75), 1'b1, 1'b0);
    check_drained("restore", e0, 0);
  endtask

  // 8'h12 has two ones, so a parity bit of 0 breaks odd parity.
  task automatic test_bad_parity();
    int e0 = err_seen;
    send_frame(8'h12, ~odd_par(8'h12), 1'b1, 1'b0);
    check_drained("bad_parity", e0, 1);
    check_scan("bad_parity", 8'h75);
  endtask

  task automatic test_bad_stop();
    int e0 = err_seen;
    send_frame(8'h33, odd_par(8'h33), 1'b0, 1'b0);
    check_drained("bad_stop", e0, 1);
    check_scan("bad_stop", 8'h75);
    e0 = err_seen;
    exp_q.push_back(8'h29);
    send_frame(8'h29, odd_par(8'h29), 1'b1, 1'b0);
    check_drained("after_bad_stop", e0, 0);
    check_scan("after_bad_stop", 8'h29);
  endtask

  task automatic test_timeout();
    int e0 = err_seen;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    wait_clks(TIMEOUT + 10);
    @(negedge clk);
    checks++;
    if (err_seen - e0 !== 1) begin
      errors++;
      $display("FAIL timeout_err count=%0d expected=1", err_seen - e0);
    end
    checks++;
    if (state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL timeout_state state=%0d expected=0", state_dbg);
    end
    check_scan("timeout", 8'h29);
    e0 = err_seen;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, odd_par(8'h5A), 1'b1, 1'b0);
    check_drained("after_timeout", e0, 0);
    check_scan("after_timeout", 8'h5A);
  endtask

  task automatic test_glitch();
    int e0 = err_seen;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, odd_par(8'hA5), 1'b1, 1'b1);
    check_drained("glitch", e0, 0);
    check_scan("glitch", 8'hA5);
  endtask

  task automatic test_reset_mid_frame();
    int e0;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    wait_clks(3);
    @(negedge clk);
    checks++;
    if ({scan, scan_received, frame_err, state_dbg} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_outputs scan=%02h sr=%b fe=%b st=%0d expected 00 0 0 0",
               scan, scan_received, frame_err, state_dbg);
    end
    ps2clk  = 1'b1;
    ps2data = 1'b1;
    rst     = 1'b0;
    e0 = err_seen;
    wait_clks(200);
    check_drained("reset_mid", e0, 0);
    check_scan("reset_mid", 8'h00);
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, odd_par(8'h1C), 1'b1, 1'b0);
    check_drained("after_reset", e0, 0);
    check_scan("after_reset", 8'h1C);
  endtask

  initial begin
    test_reset();
    test_clean();
    test_sequence();
    test_random();
    test_bad_parity();
    test_bad_stop();
    test_timeout();
    test_glitch();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
